pipeif_fetchq: RTL

Parametrised instruction-fetch stage for the pipelined CPU. It owns the PC register, issues word reads to a one-cycle-latency synchronous instruction ROM, and buffers fetched instructions in a QDEPTH-entry queue. It presents a valid/ready handshake to the ID stage. Redirects from ID (branch, jump-register, jump) flush the queue and discard the in-flight read.

---
 rtl/pipeif_pkg.sv | 28 ++
 rtl/pipeif_fetchq_if.sv | 25 ++
 rtl/pipeif_fifo.sv | 49 ++++
 rtl/pipeif_fetchq.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pipeif_pkg.sv
// Shared definitions for the instruction-fetch stage: redirect encodings,
// the default queue-entry layout and a pointer-width helper.
package pipeif_pkg;

   typedef enum logic [1:0] {
      PCS_SEQ = 2'b00,
      PCS_BR  = 2'b01,
      PCS_JR  = 2'b10,
      PCS_J   = 2'b11
   } pcs_e;

   localparam int FQ_XLEN = 32;

   typedef struct packed {
      logic [FQ_XLEN-1:0] pc;
      logic [FQ_XLEN-1:0] ins;
   } fq_entry_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pipeif_fetchq_if.sv
// Fetch-stage bus: instruction ROM port plus the valid/ready handshake to ID.
// master = fetch stage, slave = ROM/ID side.
interface pipeif_fetchq_if #(
   parameter int XLEN    = 32,
   parameter int IMEM_AW = 6
);
   logic               imem_rd;
   logic [IMEM_AW-1:0] imem_addr;
   logic [XLEN-1:0]    imem_rdata;
   logic               if_valid;
   logic [XLEN-1:0]    if_ins;
   logic [XLEN-1:0]    if_pc;
   logic [XLEN-1:0]    if_pc4;
   logic               id_ready;

   modport master (
      output imem_rd, imem_addr, if_valid, if_ins, if_pc, if_pc4,
      input  imem_rdata, id_ready
   );

   modport slave (
      input  imem_rd, imem_addr, if_valid, if_ins, if_pc, if_pc4,
      output imem_rdata, id_ready
   );
endinterface

// File: rtl/pipeif_fifo.sv
// QDEPTH-entry synchronous queue of fetched {pc, ins} entries with flush.
// Pointers wrap naturally because QDEPTH is a power of two.
module pipeif_fifo
   import pipeif_pkg::*;
#(
   parameter int  QDEPTH  = 4,
   parameter type entry_t = fq_entry_t,
   localparam int PW      = clog2(QDEPTH)
) (
   input  logic    clock,
   input  logic    resetn,
   input  logic    push,
   input  logic    pop,
   input  logic    flush,
   input  entry_t  din,
   output entry_t  head,
   output logic [PW:0] count
);

   entry_t        mem_r [QDEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW:0]   count_r;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         if (pop)  rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         count_r <= count_r + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

   // Storage needs no reset: head is only observed while count is nonzero.
   always_ff @(posedge clock) begin
      if (push && !flush) mem_r[wr_ptr_r] <= din;
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/pipeif_fetchq.sv
// Instruction-fetch stage: PC, one-cycle ROM reads, fetch queue and redirect.
// Optional IF_PERF_EN adds perf_fetch/perf_flush event counters.
module pipeif_fetchq
   import pipeif_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              IMEM_AW  = 6,
   parameter int              QDEPTH   = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [1:0]       pcsource,
   input  logic [XLEN-1:0]  bpc,
   input  logic [XLEN-1:0]  rpc,
   input  logic [XLEN-1:0]  jpc,
   pipeif_fetchq_if.master  bus,
   output logic             misalign_err
`ifdef IF_PERF_EN
   ,
   output logic [31:0]      perf_fetch,
   output logic [31:0]      perf_flush
`endif
);

   localparam int PW = clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam int SW = CW + 1;
   localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] ins;
   } entry_t;

   logic [XLEN-1:0] pc_r, tag_r, target_s;
   logic            inflight_r, kill_r, misalign_r;
   logic            redirect_s, pop_s, push_s, issue_s, valid_s;
   logic [CW-1:0]   count_s;
   entry_t          head_s, din_s;

   always_comb begin
      target_s = pc_r;
      case (pcsource)
         PCS_BR:  target_s = bpc;
         PCS_JR:  target_s = rpc;
         PCS_J:   target_s = jpc;
         default: target_s = pc_r;
      endcase
   end

   // Redirect beats everything; issue is held off during reset so the ROM sees no strobe.
   always_comb begin
      redirect_s = (pcsource != PCS_SEQ);
      valid_s    = (count_s != '0);
      pop_s      = valid_s && bus.id_ready && !redirect_s;
      push_s     = inflight_r && !kill_r && !redirect_s;
      issue_s    = resetn && !redirect_s &&
                   (((SW'(count_s) + SW'(inflight_r)) < SW'(QDEPTH)) || pop_s);
      din_s      = '{pc: tag_r, ins: bus.imem_rdata};
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pc_r       <= RESET_PC;
         tag_r      <= '0;
         inflight_r <= 1'b0;
         kill_r     <= 1'b0;
         misalign_r <= 1'b0;
      end else begin
         inflight_r <= issue_s;
         kill_r     <= redirect_s;
         if (redirect_s) begin
            pc_r <= {target_s[XLEN-1:2], 2'b00};
            if (target_s[1:0] != 2'b00) misalign_r <= 1'b1;
         end else if (issue_s) begin
            pc_r  <= pc_r + PC_STEP;
            tag_r <= pc_r;
         end
      end
   end

   pipeif_fifo #(
      .QDEPTH  (QDEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .push   (push_s),
      .pop    (pop_s),
      .flush  (redirect_s),
      .din    (din_s),
      .head   (head_s),
      .count  (count_s)
   );

   // Head fields read as zero while the queue is empty.
   always_comb begin
      bus.imem_rd   = issue_s;
      bus.imem_addr = pc_r[IMEM_AW+1:2];
      bus.if_valid  = valid_s;
      if (valid_s) begin
         bus.if_ins = head_s.ins;
         bus.if_pc  = head_s.pc;
         bus.if_pc4 = head_s.pc + PC_STEP;
      end else begin
         bus.if_ins = '0;
         bus.if_pc  = '0;
         bus.if_pc4 = '0;
      end
   end

   assign misalign_err = misalign_r;

`ifdef IF_PERF_EN
   logic [31:0] perf_fetch_r, perf_flush_r;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         perf_fetch_r <= 32'd0;
         perf_flush_r <= 32'd0;
      end else begin
         if (push_s)     perf_fetch_r <= perf_fetch_r + 32'd1;
         if (redirect_s) perf_flush_r <= perf_flush_r + 32'd1;
      end
   end

   assign perf_fetch = perf_fetch_r;
   assign perf_flush = perf_flush_r;
`endif

endmodule
